// File: rtl/tt_cnt_bank_pkg.sv
// tt_cnt_bank_pkg
// Shared types and constants for the counter bank:
//   op_e    - 2-bit operation encoding carried on ui_in[7:6]
//   state_e - sweep/run controller states
//   UIO_OE  - fixed output-enable pattern for the bidirectional pins
package tt_cnt_bank_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_INC = 2'b01,
    OP_CLR = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [7:0] UIO_OE = 8'hC0;

endpackage

// File: rtl/tt_cnt_bank_if.sv
// tt_cnt_bank_if
// Storage access bus between the counter-bank controller and its memory.
//   we/waddr/wdata - single synchronous write port
//   raddr/rdata    - combinational read port
// Modports: master (controller), slave (memory).
interface tt_cnt_bank_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;

  modport master (output we, waddr, wdata, raddr, input rdata);
  modport slave  (input we, waddr, wdata, raddr, output rdata);

endinterface

// File: rtl/tt_cnt_bank_mem.sv
// tt_cnt_bank_mem
// DEPTH x WIDTH counter storage. One synchronous write port, one
// combinational read port. Contents are not reset; the controller clears
// them with its sweep.
// Ports:
//   clk - clock
//   bus - tt_cnt_bank_if slave modport
module tt_cnt_bank_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input logic           clk,
  tt_cnt_bank_if.slave  bus
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (bus.we) begin
      r_mem[bus.waddr] <= bus.wdata;
    end
  end

  assign bus.rdata = r_mem[bus.raddr];

endmodule

// File: rtl/tt_um_cnt_bank.sv
// tt_um_cnt_bank
// Bank of DEPTH counters, WIDTH bits each, driven through the TinyTapeout
// pin set. After reset a sweep clears every counter (busy=1), then each
// enabled cycle performs one op on the addressed counter.
// Ports:
//   clk     - clock
//   rst_n   - synchronous active-low reset
//   ena     - operation enable
//   ui_in   - [7:6] op, [5] sat_mode, [4] byte select, [3:0] address
//   uio_in  - [5:0] ADD amount
//   uo_out  - registered read byte (pre-update value of addressed counter)
//   uio_out - [7] busy, [6] sticky overflow, [5:0] zero
//   uio_oe  - constant 8'hC0
// Build option: define CNT_BANK_SAT_EN to honour ui_in[5] (saturate on
// overflow); otherwise counters always wrap.
module tt_um_cnt_bank
  import tt_cnt_bank_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned AW = $clog2(DEPTH);

  tt_cnt_bank_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) w_mem_if ();

  tt_cnt_bank_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .clk (clk),
    .bus (w_mem_if)
  );

  state_e        r_state;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_uo;
  logic          r_ovf;
  logic          r_busy;

  op_e              w_op;
  logic [AW-1:0]    w_addr;
  logic             w_bsel;
  logic             w_sat;
  logic [WIDTH:0]   w_amt;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic             w_arith;
  logic [WIDTH-1:0] w_new;
  logic [15:0]      w_ext;
  logic [7:0]       w_rd_byte;
  logic             w_unused;

  assign w_op   = op_e'(ui_in[7:6]);
  assign w_addr = ui_in[AW-1:0];
  assign w_bsel = ui_in[4];

`ifdef CNT_BANK_SAT_EN
  assign w_sat = ui_in[5];
`else
  assign w_sat = 1'b0;
`endif

  // Pins not consumed in every configuration.
  assign w_unused = ^{ui_in, uio_in};

  assign w_arith = (w_op == OP_INC) || (w_op == OP_ADD);

  // One extra bit on the adder exposes overflow directly; ADD 0 can never
  // carry, so it never flags overflow.
  always_comb begin
    w_amt = '0;
    if (w_op == OP_INC) begin
      w_amt[0] = 1'b1;
    end else begin
      w_amt[5:0] = uio_in[5:0];
    end
    w_sum   = {1'b0, w_mem_if.rdata} + w_amt;
    w_carry = w_sum[WIDTH];
    if (w_op == OP_CLR) begin
      w_new = '0;
    end else if (w_carry && w_sat) begin
      w_new = '1;
    end else begin
      w_new = w_sum[WIDTH-1:0];
    end
  end

  always_comb begin
    w_ext            = '0;
    w_ext[WIDTH-1:0] = w_mem_if.rdata;
    w_rd_byte        = w_bsel ? w_ext[15:8] : w_ext[7:0];
  end

  // Read and update share the addressed location; the write lands on the
  // clock edge, so the registered read naturally holds the pre-update value.
  always_comb begin
    w_mem_if.we    = 1'b0;
    w_mem_if.waddr = w_addr;
    w_mem_if.wdata = '0;
    w_mem_if.raddr = w_addr;
    if (rst_n) begin
      if (r_state == ST_SWEEP) begin
        w_mem_if.we    = 1'b1;
        w_mem_if.waddr = r_idx;
      end else if (ena && (w_op != OP_NOP)) begin
        w_mem_if.we    = 1'b1;
        w_mem_if.wdata = w_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_SWEEP;
      r_idx   <= '0;
      r_uo    <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_SWEEP: begin
          r_uo  <= '0;
          r_idx <= r_idx + AW'(1);
          if (r_idx == AW'(DEPTH - 1)) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_uo <= w_rd_byte;
          if (ena && w_arith && w_carry) begin
            r_ovf <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_SWEEP;
          r_idx   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign uo_out  = r_uo;
  assign uio_out = {r_busy, r_ovf, 6'b000000};
  assign uio_oe  = UIO_OE;

endmodule

// File: doc/tt_um_cnt_bank.md
TT_UM_CNT_BANK -- requirements
Module: tt_um_cnt_bank

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of counters (power of 2, 2..16).
REQ-002 SHALL have parameter WIDTH, default 16, meaning the counter width in bits (9..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port ena, input, 1 bit: operation enable.
REQ-006 SHALL have port ui_in, input, 8 bits: [7:6] op, [5] sat_mode, [4] byte select, [3:0] address.
REQ-007 SHALL have port uio_in, input, 8 bits: [5:0] ADD amount; [7:6] ignored.
REQ-008 SHALL have port uo_out, output, 8 bits: registered read data byte.
REQ-009 SHALL have port uio_out, output, 8 bits: [7] busy, [6] sticky overflow, [5:0] zero.
REQ-010 SHALL have port uio_oe, output, 8 bits: constant 8'hC0.

Function
REQ-011 SHALL decode op as 00 NOP, 01 INC (+1), 10 CLR (write 0), 11 ADD (+uio_in[5:0], zero-extended).
REQ-012 SHALL decode the counter index as ui_in[log2(DEPTH)-1:0]; upper address bits SHALL be ignored.
REQ-013 SHALL execute the op every clk cycle with ena=1 and state RUN: level-sensitive, one update per cycle.
REQ-014 SHALL ignore ops when ena=0 or state SWEEP; counters SHALL hold.
REQ-015 SHALL use FSM states SWEEP and RUN; SWEEP writes 0 to index idx, idx+1 per cycle, and moves to RUN after index DEPTH-1.
REQ-016 SHALL complete SWEEP in exactly DEPTH cycles after rst_n deasserts; busy=1 throughout SWEEP, 0 in RUN.
REQ-017 SHALL wrap modulo 2^WIDTH on INC/ADD overflow when sat_mode=0.
REQ-018 SHALL clamp to 2^WIDTH-1 on overflow when sat_mode=1 (see Configuration).
REQ-019 SHALL set sticky overflow when any INC/ADD result exceeds 2^WIDTH-1; only reset clears it, and CLR does not.
REQ-020 SHALL register uo_out with one-cycle latency: byte select 0 gives bits [7:0], 1 gives bits [WIDTH-1:8] zero-extended.
REQ-021 SHALL read before write: when the read and an update hit the same index in one cycle, uo_out SHALL show the pre-update value.
REQ-022 SHALL drive uo_out=0 during SWEEP.
REQ-023 SHALL treat ADD with amount 0 as a no-change write that never sets overflow.

Reset
REQ-024 SHALL, while rst_n=0 at a clk edge, force state SWEEP, idx=0, uo_out=0, overflow=0, busy=1.
REQ-025 SHALL abandon a sweep or a RUN operation on reset assertion and restart the sweep from index 0.
REQ-026 SHALL NOT reset storage directly; storage is cleared only by the sweep.

Configuration
REQ-027 SHALL enable saturation support with macro CNT_BANK_SAT_EN; when it is defined, REQ-018 applies.
REQ-028 SHALL, when CNT_BANK_SAT_EN is undefined, ignore ui_in[5], always wrap, and still set overflow.

Structure
REQ-029 SHALL place op encoding (enum), FSM state enum, and the UIO_OE constant in package tt_cnt_bank_pkg.
REQ-030 SHALL place storage in sub-module tt_cnt_bank_mem: DEPTH x WIDTH, one synchronous write port, one read port.
REQ-031 SHALL keep the FSM, arithmetic, saturation and output muxing in tt_um_cnt_bank.

Verification
REQ-032 Reset and sweep: rst_n low 2 cycles, then high -> busy=1 for exactly 16 cycles, then 0; every counter reads 0.
REQ-033 Increment and byte select: INC on addr 3, ena=1, 5 cycles -> lo byte 0x05, hi byte 0x00; read-before-write shows 0x04 on the cycle of the 5th INC.
REQ-034 Wrap: ADD 63 on addr 1 until past 0xFFFF, sat_mode=0 -> value wraps mod 65536 and overflow=1.
REQ-035 Saturate: same as REQ-034 with sat_mode=1 and CNT_BANK_SAT_EN defined -> value stays 0xFFFF and overflow=1; with the macro undefined -> value wraps.
REQ-036 Gating and CLR: INC with ena=0 for 10 cycles -> no change; CLR on addr 3 -> reads 0 and overflow stays 1.
REQ-037 Mid-operation reset: rst_n low during active INC -> counters 0 after a new 16-cycle sweep and overflow=0.
